// File: rtl/mem_port_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arb_pkg
//  Description : Shared definitions for the instruction/data memory-port
//                arbiter: FSM state encoding, access-size select codes,
//                the registered transaction record and address constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arb_pkg;

   // Arbiter FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Data access size select codes. Any other code behaves as SZ_SW.
   typedef logic [2:0] dsize_t;
   localparam dsize_t SZ_SB  = 3'b000;
   localparam dsize_t SZ_SH  = 3'b001;
   localparam dsize_t SZ_SW  = 3'b010;
   localparam dsize_t SZ_SBU = 3'b100;
   localparam dsize_t SZ_SHU = 3'b101;

   // Fetch addresses are word aligned; the low two bits are dropped.
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   // Transaction captured at grant time and held until the response.
   typedef struct packed {
      logic        own_data;   // 1 = data port owns the transaction
      logic        we;
      dsize_t      size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xact_t;

endpackage : mem_port_arb_pkg
`default_nettype wire

// File: rtl/lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lane_align
//  Description : Purely combinational byte-lane steering for the memory port.
//                Produces store byte enables and lane-replicated store data,
//                extracts and extends load data, and flags misaligned
//                halfword/word accesses.
//  Revision    : 1.0 - initial release
//
//  Ports
//    size_i      access size code (SB/SH/SW/SBU/SHU, others act as SW)
//    addr_lo_i   byte offset within the word
//    wdata_i     right-aligned store data
//    rdata_i     raw RAM read word
//    st_be_o     store byte-lane enables (bit n = byte n)
//    st_wdata_o  store data replicated across lanes
//    ld_data_o   selected and sign/zero-extended load data
//    misalign_o  access straddles its natural alignment
// ============================================================================
module lane_align
   import mem_port_arb_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo_i)
         2'd0:    w_byte = rdata_i[7:0];
         2'd1:    w_byte = rdata_i[15:8];
         2'd2:    w_byte = rdata_i[23:16];
         default: w_byte = rdata_i[31:24];
      endcase
   end

   // Halfword lane is chosen by addr[1] alone; addr[0] only matters for
   // the misalign flag.
   assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      st_be_o    = 4'b1111;
      st_wdata_o = wdata_i;
      ld_data_o  = rdata_i;
      misalign_o = 1'b0;
      case (size_i)
         SZ_SB, SZ_SBU: begin
            st_be_o    = 4'b0001 << addr_lo_i;
            st_wdata_o = {4{wdata_i[7:0]}};
            ld_data_o  = (size_i == SZ_SB) ? {{24{w_byte[7]}}, w_byte}
                                            : {24'd0, w_byte};
         end
         SZ_SH, SZ_SHU: begin
            st_be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            st_wdata_o = {2{wdata_i[15:0]}};
            ld_data_o  = (size_i == SZ_SH) ? {{16{w_half[15]}}, w_half}
                                            : {16'd0, w_half};
            misalign_o = addr_lo_i[0];
         end
         default: begin
            misalign_o = (addr_lo_i != 2'b00);
         end
      endcase
   end

endmodule : lane_align
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arb
//  Description : Arbitrates an instruction-fetch port and a load/store data
//                port onto one single-port synchronous RAM. One transaction
//                is in flight at a time: grant (IDLE) -> RAM cycle (ACCESS)
//                -> response pulse (RESP). Simultaneous requests alternate,
//                with the data port winning first after reset.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                  core clock, synchronous active-high reset
//    if_req_i/if_addr_i        fetch request and byte address
//    if_gnt_o                  fetch accepted this cycle
//    if_valid_o/if_rdata_o     fetch response pulse and word
//    d_req_i/d_we_i/d_size_i   data request, store flag, access size
//    d_addr_i/d_wdata_i        data byte address, right-aligned store data
//    d_gnt_o                   data accepted this cycle
//    d_valid_o/d_rdata_o       data completion pulse and load data
//    d_err_o                   misaligned access, qualified by d_valid_o
//    mem_addr_o/mem_we_o       RAM word address and write strobe
//    mem_be_o/mem_wdata_o      RAM byte enables and lane-replicated data
//    mem_rdata_i               RAM read data, one cycle after address
// ============================================================================
module mem_port_arb
   import mem_port_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_valid_o,
   output logic [31:0] if_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [2:0]  d_size_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_valid_o,
   output logic [31:0] d_rdata_o,
   output logic        d_err_o,
   output logic [29:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   logic [1:0]  state_q, state_d;
   logic        last_data_q, last_data_d;
   xact_t       xact_q, xact_d;

   logic        w_gnt_if;
   logic        w_gnt_data;
   logic        w_in_access;
   logic        w_in_resp;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_data;
   logic        w_misalign;

   // ------------------------------------------------------------------
   // Next-state and arbitration
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      xact_d      = xact_q;
      w_gnt_if    = 1'b0;
      w_gnt_data  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Grants are suppressed in the reset cycle so nothing is
            // accepted that the reset would then discard.
            if (!rst) begin
               w_gnt_data = d_req_i && (!if_req_i || !last_data_q);
               w_gnt_if   = if_req_i && !w_gnt_data;
            end
            if (w_gnt_data) begin
               xact_d.own_data = 1'b1;
               xact_d.we       = d_we_i;
               xact_d.size     = d_size_i;
               xact_d.addr     = d_addr_i;
               xact_d.wdata    = d_wdata_i;
               last_data_d     = 1'b1;
               state_d         = ST_ACCESS;
            end else if (w_gnt_if) begin
               // A fetch is an aligned word load.
               xact_d.own_data = 1'b0;
               xact_d.we       = 1'b0;
               xact_d.size     = SZ_SW;
               xact_d.addr     = if_addr_i & WORD_MASK;
               xact_d.wdata    = 32'd0;
               last_data_d     = 1'b0;
               state_d         = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_data_q <= 1'b0;
         xact_q      <= '0;
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         xact_q      <= xact_d;
      end
   end

   // ------------------------------------------------------------------
   // Lane steering for the transaction in flight
   // ------------------------------------------------------------------
   lane_align u_lane_align (
      .size_i     (xact_q.size),
      .addr_lo_i  (xact_q.addr[1:0]),
      .wdata_i    (xact_q.wdata),
      .rdata_i    (mem_rdata_i),
      .st_be_o    (w_st_be),
      .st_wdata_o (w_st_wdata),
      .ld_data_o  (w_ld_data),
      .misalign_o (w_misalign)
   );

   // ------------------------------------------------------------------
   // Outputs. Phase strobes are masked by rst so an in-flight
   // transaction is killed in the very cycle reset is seen.
   // ------------------------------------------------------------------
   assign w_in_access = (state_q == ST_ACCESS) && !rst;
   assign w_in_resp   = (state_q == ST_RESP)   && !rst;

   assign if_gnt_o    = w_gnt_if;
   assign d_gnt_o     = w_gnt_data;

   // The address register only changes at grant, so it holds its value
   // through RESP and IDLE.
   assign mem_addr_o  = xact_q.addr[31:2];
   assign mem_wdata_o = w_st_wdata;
   assign mem_we_o    = w_in_access && xact_q.we && !w_misalign;
   assign mem_be_o    = (w_in_access && !w_misalign)
                        ? (xact_q.we ? w_st_be : 4'b1111)
                        : 4'b0000;

   assign if_valid_o  = w_in_resp && !xact_q.own_data;
   assign if_rdata_o  = if_valid_o ? mem_rdata_i : 32'd0;

   assign d_valid_o   = w_in_resp && xact_q.own_data;
   assign d_err_o     = d_valid_o && w_misalign;
   assign d_rdata_o   = (d_valid_o && !w_misalign && !xact_q.we) ? w_ld_data
                                                                 : 32'd0;

endmodule : mem_port_arb
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arb
//  Description : Self-checking bench for mem_port_arb. A transaction-level
//                reference model (arbitration rule, byte-addressed memory
//                image, load extension arithmetic) predicts every grant,
//                RAM cycle and response; directed cases cover the named
//                scenarios, followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;
   import mem_port_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [2:0]  d_size;
   logic        if_gnt, if_valid, d_gnt, d_valid, d_err, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   mem_port_arb dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_valid_o(if_valid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_valid_o(d_valid),
      .d_rdata_o(d_rdata), .d_err_o(d_err),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // ---------------- RAM environment (written only by the DUT, plus preload)
   logic [31:0] ram [256];
   logic        pk_en = 1'b0;
   logic [7:0]  pk_idx;
   logic [31:0] pk_val;

   always @(posedge clk) begin
      if (pk_en) ram[pk_idx] <= pk_val;
      else begin
         for (int i = 0; i < 4; i++)
            if (mem_we && mem_be[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= ram[mem_addr[7:0]];
   end

   // ---------------- checking
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model helpers
   logic [31:0] ref_mem [256];

   function automatic logic [2:0] norm_size(input logic [2:0] s);
      if (s == SZ_SB || s == SZ_SH || s == SZ_SBU || s == SZ_SHU) return s;
      return SZ_SW;
   endfunction

   function automatic logic is_half(input logic [2:0] s);
      return (s == SZ_SH) || (s == SZ_SHU);
   endfunction

   function automatic logic [31:0] ld_expect(input logic [31:0] w, input logic [2:0] sz,
                                             input logic [1:0] off);
      logic [31:0] b, h;
      b = (w >> (int'(off) * 8)) & 32'h0000_00FF;
      h = (w >> (int'(off[1]) * 16)) & 32'h0000_FFFF;
      case (sz)
         SZ_SB:   return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
         SZ_SBU:  return b;
         SZ_SH:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         SZ_SHU:  return h;
         default: return w;
      endcase
   endfunction

   // ---------------- monitor / scoreboard (samples on the falling edge)
   int          cyc = 0, gcyc = 0, cap_lat = 0, dvalid_cnt = 0, phase = 0;
   logic        last_data = 1'b0;
   logic        gnt_if_seen = 1'b0, gnt_d_seen = 1'b0;
   logic        eg_d, eg_i, e_we;
   logic        t_is_d, t_we, t_mis;
   logic [2:0]  t_sz;
   logic [31:0] t_a, t_wd, e_wd;
   logic [3:0]  e_be;
   logic [31:0] cap_drdata, cap_ifrdata, cap_wdata;
   logic        cap_derr;
   logic [3:0]  cap_be;
   logic [29:0] cap_maddr;
   bit          gnt_log [$];

   always @(negedge clk) begin
      cyc++;
      gnt_if_seen = if_gnt;
      gnt_d_seen  = d_gnt;
      if (if_gnt || d_gnt) begin gcyc = cyc; gnt_log.push_back(d_gnt); end
      if (if_valid || d_valid) cap_lat = cyc - gcyc;
      if (d_valid) begin cap_drdata = d_rdata; cap_derr = d_err; dvalid_cnt++; end
      if (if_valid) cap_ifrdata = if_rdata;

      if (rst) begin
         chk("rst_outputs", 32'({if_gnt, d_gnt, if_valid, d_valid, d_err, mem_we, mem_be}), 32'd0);
         phase     = 0;
         last_data = 1'b0;
      end else begin
         eg_d = (phase == 0) && d_req && (!if_req || !last_data);
         eg_i = (phase == 0) && if_req && !eg_d;
         chk("grant", 32'({if_gnt, d_gnt}), 32'({eg_i, eg_d}));
         case (phase)
            1: begin
               e_we = t_is_d && t_we && !t_mis;
               if (t_mis)                e_be = 4'h0;
               else if (!e_we)           e_be = 4'hF;
               else if (t_sz == SZ_SB)   e_be = 4'(1 << t_a[1:0]);
               else if (is_half(t_sz))   e_be = t_a[1] ? 4'hC : 4'h3;
               else                      e_be = 4'hF;
               if (t_sz == SZ_SB)        e_wd = {4{t_wd[7:0]}};
               else if (is_half(t_sz))   e_wd = {2{t_wd[15:0]}};
               else                      e_wd = t_wd;
               chk("mem_addr", 32'(mem_addr), 32'(t_a[31:2]));
               chk("mem_we", 32'(mem_we), 32'(e_we));
               chk("mem_be", 32'(mem_be), 32'(e_be));
               chk("access_valids", 32'({if_valid, d_valid}), 32'd0);
               if (e_we) begin
                  chk("mem_wdata", mem_wdata, e_wd);
                  for (int i = 0; i < 4; i++)
                     if (e_be[i]) ref_mem[t_a[9:2]][8*i +: 8] = e_wd[8*i +: 8];
               end
               cap_be = mem_be; cap_wdata = mem_wdata; cap_maddr = mem_addr;
               phase = 2;
            end
            2: begin
               chk("resp_mem_idle", 32'({mem_we, mem_be}), 32'd0);
               if (t_is_d) begin
                  chk("d_valid", 32'({if_valid, d_valid}), 32'h1);
                  chk("d_err", 32'(d_err), 32'(t_mis));
                  chk("d_rdata", d_rdata, (t_mis || t_we) ? 32'd0
                                          : ld_expect(ref_mem[t_a[9:2]], t_sz, t_a[1:0]));
               end else begin
                  chk("if_valid", 32'({if_valid, d_valid}), 32'h2);
                  chk("if_rdata", if_rdata, ref_mem[t_a[9:2]]);
               end
               phase = 0;
            end
            default: begin
               chk("idle_outputs", 32'({if_valid, d_valid, mem_we, mem_be}), 32'd0);
               if (eg_d) begin
                  t_is_d = 1'b1; t_we = d_we; t_sz = norm_size(d_size);
                  t_a = d_addr; t_wd = d_wdata;
                  t_mis = (is_half(t_sz) && t_a[0]) || (t_sz == SZ_SW && t_a[1:0] != 2'b00);
                  last_data = 1'b1; phase = 1;
               end else if (eg_i) begin
                  t_is_d = 1'b0; t_we = 1'b0; t_sz = SZ_SW;
                  t_a = if_addr; t_wd = 32'd0; t_mis = 1'b0;
                  last_data = 1'b0; phase = 1;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(posedge clk); #1;
      if (gnt_if_seen) if_req = 1'b0;
      if (gnt_d_seen)  d_req  = 1'b0;
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      pk_en = 1'b1; pk_idx = 8'(idx); pk_val = v; ref_mem[idx] = v;
      tick();
      pk_en = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      tick();
      while ((if_req || d_req || phase != 0) && n < 40) begin tick(); n++; end
      if (n >= 40) chk("timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); tick(); tick(); rst = 1'b0;
   endtask

   task automatic issue_data(input logic we, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
   endtask

   task automatic do_data(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      issue_data(we, sz, a, wd);
      wait_done();
   endtask

   // ---------------- test sequence
   initial begin
      int          cnt0;
      int          n;
      logic [4:0]  order;
      logic [2:0]  rs;

      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_size = SZ_SW;
      for (int i = 0; i < 256; i++) poke(i, $urandom);
      tick(); rst = 1'b0;
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);

      // Fetch only
      poke(8'h40, 32'hDEAD_BEEF);
      if_req = 1'b1; if_addr = 32'h100;
      wait_done();
      chk("fetch_maddr", 32'(cap_maddr), 32'h40);
      chk("fetch_rdata", cap_ifrdata, 32'hDEAD_BEEF);
      chk("fetch_latency", 32'(cap_lat), 32'd2);

      // Arbitration order from reset
      do_reset();
      gnt_log.delete();
      if_req = 1'b1; if_addr = 32'h10; issue_data(1'b0, SZ_SW, 32'h20, 32'd0);
      wait_done();
      do_data(1'b0, SZ_SW, 32'h24, 32'd0);
      if_req = 1'b1; if_addr = 32'h14; issue_data(1'b0, SZ_SW, 32'h28, 32'd0);
      wait_done();
      order = 5'b10101;
      chk("arb_count", 32'(gnt_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < gnt_log.size()) chk("arb_order", 32'(gnt_log[i]), 32'(order[4-i]));

      // SB store to the top byte lane
      do_data(1'b1, SZ_SB, 32'h203, 32'h0000_00A5);
      chk("sb_be", 32'(cap_be), 32'h8);
      chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      chk("sb_maddr", 32'(cap_maddr), 32'h80);
      chk("sb_latency", 32'(cap_lat), 32'd2);

      // Load extraction and extension
      poke(8'h90, 32'h80F0_FF7F);
      do_data(1'b0, SZ_SB,  32'h240, 32'd0); chk("ld_sb0",  cap_drdata, 32'h0000_007F);
      do_data(1'b0, SZ_SB,  32'h241, 32'd0); chk("ld_sb1",  cap_drdata, 32'hFFFF_FFFF);
      do_data(1'b0, SZ_SHU, 32'h242, 32'd0); chk("ld_shu2", cap_drdata, 32'h0000_80F0);
      do_data(1'b0, SZ_SH,  32'h242, 32'd0); chk("ld_sh2",  cap_drdata, 32'hFFFF_80F0);

      // Misaligned word store, then a normal access
      do_data(1'b1, SZ_SW, 32'h202, 32'h1234_5678);
      chk("mis_err", 32'(cap_derr), 32'd1);
      chk("mis_rdata", cap_drdata, 32'd0);
      chk("mis_be", 32'(cap_be), 32'd0);
      do_data(1'b0, SZ_SW, 32'h240, 32'd0);
      chk("after_mis_err", 32'(cap_derr), 32'd0);
      chk("after_mis_rdata", cap_drdata, 32'h80F0_FF7F);

      // Reset during the RAM cycle of a store
      cnt0 = dvalid_cnt;
      issue_data(1'b1, SZ_SW, 32'h100, 32'h1234_5678);
      n = 0;
      while (d_req && n < 20) begin tick(); n++; end
      if (n >= 20) chk("rst_store_gnt_timeout", 32'd1, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      issue_data(1'b0, SZ_SW, 32'h100, 32'd0);
      @(negedge clk);
      chk("post_rst_gnt", 32'(d_gnt), 32'd1);
      wait_done();
      chk("rst_valid_count", 32'(dvalid_cnt - cnt0), 32'd1);
      chk("rst_no_write", cap_drdata, 32'hDEAD_BEEF);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         if (k == 300) begin rst = 1'b1; tick(); tick(); rst = 1'b0; end
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 32'($urandom_range(0, 1023));
         end
         if (!d_req && $urandom_range(0, 1) == 0) begin
            rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
               if (rs == SZ_SBU || rs == SZ_SHU) rs = SZ_SB;
               issue_data(1'b1, rs, 32'($urandom_range(0, 1023)), $urandom);
            end else begin
               issue_data(1'b0, rs, 32'($urandom_range(0, 1023)), $urandom);
            end
         end
         tick();
      end
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

endmodule : tb_mem_port_arb
`default_nettype wire

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 clk  in  1  core clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 if_req  in  1  instruction-fetch request, held until if_gnt.
REQ-004 if_addr  in  32  fetch byte address (word-aligned; addr[1:0] ignored).
REQ-005 if_gnt  out  1  fetch request accepted this cycle.
REQ-006 if_valid  out  1  one-cycle pulse; if_rdata valid.
REQ-007 if_rdata  out  32  fetched word.
REQ-008 d_req  in  1  data request from load/store path, held until d_gnt.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_size  in  3  access type, shared codes SB/SH/SW/SBU/SHU.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data, right-aligned.
REQ-013 d_gnt  out  1  data request accepted this cycle.
REQ-014 d_valid  out  1  one-cycle completion pulse for loads and stores.
REQ-015 d_rdata  out  32  load data, extended per d_size; 0 for stores.
REQ-016 d_err  out  1  misaligned access; qualified by d_valid.
REQ-017 mem_addr  out  30  word address to single-port synchronous RAM.
REQ-018 mem_we  out  1  RAM write strobe.
REQ-019 mem_be  out  4  byte-lane enables, bit n = byte n (little-endian).
REQ-020 mem_wdata  out  32  lane-replicated write data.
REQ-021 mem_rdata  in  32  RAM read data, valid one cycle after address.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-023 IDLE: if_gnt/d_gnt are combinational from requests; the granted request's address, size, we and wdata are registered; next state ACCESS.
REQ-024 Only one request pending: grant it. Both pending: grant the requester not granted last (last_d flag, reset 0, so data wins first).
REQ-025 ACCESS: drive mem_addr = addr[31:2], mem_be, mem_we (stores only) for exactly one cycle; next RESP.
REQ-026 RESP: pulse if_valid or d_valid for the owner; next IDLE. Grant-to-valid latency is 2 cycles; no grant in ACCESS or RESP.
REQ-027 Store lanes: SB -> be = 1 << addr[1:0], wdata = byte replicated x4; SH -> be = 0011 (addr[1]=0) or 1100, halfword replicated x2; SW -> 1111, wdata unchanged.
REQ-028 Loads: mem_we = 0, mem_be = 1111; d_rdata selects byte/halfword by addr[1:0]; SB/SH sign-extend, SBU/SHU zero-extend, SW unchanged.
REQ-029 Misaligned (SH/SHU with addr[0]=1; SW with addr[1:0] != 0): ACCESS issues no RAM access (mem_we = 0, mem_be = 0000); RESP pulses d_valid with d_err = 1, d_rdata = 0.
REQ-030 Unknown d_size code is treated as SW.
REQ-031 Outside ACCESS: mem_we = 0, mem_be = 0000, mem_addr holds its last value.
REQ-032 if_rdata = mem_rdata in the fetch RESP cycle; d_rdata and if_rdata are 0 when their valid is low.

Reset
REQ-033 rst forces IDLE and last_d = 0; the same cycle drives all grants, valids, d_err, mem_we and mem_be to 0. An in-flight transaction is dropped with no valid pulse and no RAM write after the reset cycle.
REQ-034 Registered mem_addr and internal request registers reset to 0.

Structure
REQ-035 FSM state encoding and d_size codes (SB/SH/SW/SBU/SHU) are defined in the shared header alongside the existing select codes; no literal codes in the module.
REQ-036 One sub-module, lane_align, is combinational: store be/wdata generation and load extraction/extension, plus the misalign flag.

Verification
REQ-037 Fetch only: if_req = 1, if_addr = 0x100, RAM[0x40] = 0xDEADBEEF -> if_gnt cycle 0, mem_addr = 0x40 cycle 1, if_valid with 0xDEADBEEF cycle 2.
REQ-038 Simultaneous if_req and d_req from reset -> data granted first, fetch granted in the next IDLE; subsequent simultaneous requests alternate.
REQ-039 SB store d_addr = 0x203, d_wdata = 0x000000A5 -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x80, d_valid 2 cycles after grant.
REQ-040 Loads from word 0x80F0FF7F: SB addr offset 0 -> 0x0000007F; SB offset 1 -> 0xFFFFFFFF; SHU offset 2 -> 0x000080F0; SH offset 2 -> 0xFFFF80F0.
REQ-041 SW at d_addr = 0x202 -> no RAM access, d_valid with d_err = 1 and d_rdata = 0; the following aligned request completes normally.
REQ-042 rst asserted during ACCESS of a store -> mem_we = 0 from the reset cycle on, no d_valid, and the FSM is in IDLE after reset deasserts.
